// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake for the UART transmitter FIFO.
// A word moves on any CLK edge where wr_valid && wr_ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular write FIFO.
// Frames go out back to back while words are queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  uart_tx_fifo_if.slave                 wr,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          idle,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 full, push, pop;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 txd_n, done_n, tick;

  assign level       = wr_ptr - rd_ptr;
  assign full        = level == (AW+1)'(FIFO_DEPTH);
  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && !full;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign busy        = state != IDLE;
  assign idle        = !busy && level == '0;
  assign tick        = cnt == CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr.wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (wr.wr_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      par        <= 1'b0;
      txd        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      par        <= par_n;
      txd        <= txd_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    txd_n   = txd;
    done_n  = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        txd_n = 1'b1;
        cnt_n = '0;
        if (level != '0) begin
          pop     = 1'b1;
          sh_n    = head;
          par_n   = (PARITY == 1) ? ~^head : ^head;
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        cnt_n = cnt + CW'(1);
        if (tick) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          txd_n   = sh[0];
        end
      end
      DATA: begin
        cnt_n = cnt + CW'(1);
        if (tick) begin
          cnt_n = '0;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_n = '0;
            if (PARITY != 0) begin
              state_n = PAR;
              txd_n   = par;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            idx_n = idx + IW'(1);
            sh_n  = sh >> 1;
            txd_n = sh[1];
          end
        end
      end
      PAR: begin
        cnt_n = cnt + CW'(1);
        if (tick) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
      STOP: begin
        cnt_n = cnt + CW'(1);
        if (tick) begin
          cnt_n = '0;
          if (idx == IW'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            idx_n  = '0;
            // chain straight into the next frame when a word waits
            if (level != '0) begin
              pop     = 1'b1;
              sh_n    = head;
              par_n   = (PARITY == 1) ? ~^head : ^head;
              state_n = START;
              txd_n   = 1'b0;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configs (8N1, 8E1, 8O1, 8N2)
// at 4 clocks per bit, checked against a frame-level model.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] wdat [4];
  logic       wval [4];
  logic       rdy [4];
  logic       txd_v [4];
  logic       busy_v [4];
  logic       idle_v [4];
  logic       done_v [4];
  logic       ovf_v [4];
  logic [4:0] lvl_v [4];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int P = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int S = (g == 3) ? 2 : 1;
    uart_tx_fifo_if #(.DATA_BITS(8)) bus ();
    assign bus.wr_data  = wdat[g];
    assign bus.wr_valid = wval[g];
    assign rdy[g]       = bus.wr_ready;
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS(8),
      .PARITY(P),
      .STOP_BITS(S),
      .FIFO_DEPTH(16)
    ) dut (
      .CLK(clk),
      .RST(rst),
      .wr(bus),
      .level(lvl_v[g]),
      .busy(busy_v[g]),
      .idle(idle_v[g]),
      .frame_done(done_v[g]),
      .overflow(ovf_v[g]),
      .txd(txd_v[g])
    );
  end

  typedef struct {
    int         g;
    logic [7:0] d;
    int         len;
    int         pb;
  } vec_t;

  vec_t tbl [7];

  function automatic int mpar(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
  endfunction

  function automatic int mpb(input int g, input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (mpar(g) == 0) return -1;
    if (mpar(g) == 2) return ones % 2;
    return 1 - (ones % 2);
  endfunction

  function automatic int mlen(input int g);
    int n = 1 + 8 + ((mpar(g) != 0) ? 1 : 0) + ((g == 3) ? 2 : 1);
    return n * CPB;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic wr1(input int g, input logic [7:0] d);
    wdat[g] = d;
    wval[g] = 1'b1;
    @(negedge clk);
    wval[g] = 1'b0;
  endtask

  task automatic wait_fall(input int g, input string n);
    int i;
    for (i = 0; i < 600 && txd_v[g] !== 1'b0; i++) @(negedge clk);
    chk({n, "_start_seen"}, int'(i < 600), 1);
  endtask

  // Starts at the negedge of the first start-bit cycle and returns
  // at the negedge of the first cycle after the last stop bit.
  task automatic expect_frame(input int g, input logic [7:0] d,
                              input int len, input int pb,
                              input string n);
    logic bits [12];
    int   errs  = 0;
    int   early = 0;
    for (int k = 0; k < 12; k++) bits[k] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (pb >= 0) bits[9] = pb[0];
    for (int k = 0; k < len; k++) begin
      if (txd_v[g] !== bits[k/CPB]) errs++;
      if (k > 0 && done_v[g] !== 1'b0) early++;
      @(negedge clk);
    end
    chk({n, "_bits"}, errs, 0);
    chk({n, "_done_early"}, early, 0);
    chk({n, "_done"}, int'(done_v[g]), 1);
  endtask

  initial begin
    logic [7:0] ovq [$];
    logic [7:0] rq [$];
    int         quiet;
    int         i;

    for (int g = 0; g < 4; g++) begin
      wdat[g] = 8'h00;
      wval[g] = 1'b0;
    end

    tbl[0] = '{0, 8'h55, 40, -1};
    tbl[1] = '{1, 8'h07, 44, 1};
    tbl[2] = '{2, 8'h07, 44, 0};
    tbl[3] = '{3, 8'h3C, 44, -1};
    tbl[4] = '{1, 8'h00, 44, 0};
    tbl[5] = '{2, 8'hFE, 44, 0};
    tbl[6] = '{0, 8'hA5, 40, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("rst_txd", int'(txd_v[g]), 1);
      chk("rst_busy", int'(busy_v[g]), 0);
      chk("rst_done", int'(done_v[g]), 0);
      chk("rst_ovf", int'(ovf_v[g]), 0);
      chk("rst_level", int'(lvl_v[g]), 0);
      chk("rst_ready", int'(rdy[g]), 1);
      chk("rst_idle", int'(idle_v[g]), 1);
    end

    for (int t = 0; t < 7; t++) begin
      wr1(tbl[t].g, tbl[t].d);
      chk("single_level1", int'(lvl_v[tbl[t].g]), 1);
      chk("single_txd_pre", int'(txd_v[tbl[t].g]), 1);
      chk("single_busy_pre", int'(busy_v[tbl[t].g]), 0);
      @(negedge clk);
      chk("single_busy", int'(busy_v[tbl[t].g]), 1);
      expect_frame(tbl[t].g, tbl[t].d, tbl[t].len, tbl[t].pb, "single");
      chk("single_idle", int'(idle_v[tbl[t].g]), 1);
    end

    fork
      begin
        wdat[0] = 8'hA1;
        wval[0] = 1'b1;
        @(negedge clk);
        chk("burst_lvl_a", int'(lvl_v[0]), 1);
        wdat[0] = 8'hB2;
        @(negedge clk);
        chk("burst_lvl_b", int'(lvl_v[0]), 1);
        wdat[0] = 8'hC3;
        @(negedge clk);
        chk("burst_peak", int'(lvl_v[0]), 2);
        wval[0] = 1'b0;
      end
      begin
        wait_fall(0, "burst");
        expect_frame(0, 8'hA1, 40, -1, "burst_a");
        expect_frame(0, 8'hB2, 40, -1, "burst_b");
        expect_frame(0, 8'hC3, 40, -1, "burst_c");
      end
    join
    chk("burst_idle", int'(idle_v[0]), 1);

    fork
      begin
        logic [7:0] d;
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(0, 50)) @(negedge clk);
          d = 8'($urandom);
          rq.push_back(d);
          wr1(2, d);
        end
      end
      begin
        logic [7:0] d;
        for (int n = 0; n < 6; n++) begin
          wait_fall(2, "rnd");
          chk("rnd_queued", int'(rq.size() > 0), 1);
          d = (rq.size() > 0) ? rq.pop_front() : 8'h00;
          expect_frame(2, d, mlen(2), mpb(2, d), "rnd");
        end
      end
    join
    chk("rnd_idle", int'(idle_v[2]), 1);

    wr1(3, 8'h96);
    wait_fall(3, "stop2");
    fork
      begin
        expect_frame(3, 8'h96, mlen(3), -1, "stop2_a");
        expect_frame(3, 8'h69, mlen(3), -1, "stop2_b");
      end
      begin
        repeat (38) @(negedge clk);
        wr1(3, 8'h69);
      end
    join

    wr1(0, 8'h11);
    for (int n = 0; n < 17; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (n == 15) chk("ovf_ready_15", int'(rdy[0]), 1);
      if (n == 16) begin
        chk("ovf_full_ready", int'(rdy[0]), 0);
        chk("ovf_full_level", int'(lvl_v[0]), 16);
      end
      if (n < 16) ovq.push_back(d);
      wdat[0] = d;
      wval[0] = 1'b1;
      @(negedge clk);
    end
    wval[0] = 1'b0;
    chk("ovf_sticky", int'(ovf_v[0]), 1);
    chk("ovf_level", int'(lvl_v[0]), 16);
    for (i = 0; i < 200 && done_v[0] !== 1'b1; i++) @(negedge clk);
    chk("ovf_first_done", int'(i < 200), 1);
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      d = ovq.pop_front();
      expect_frame(0, d, 40, mpb(0, d), "ovf_q");
    end
    chk("ovf_drained", int'(idle_v[0]), 1);

    for (int n = 0; n < 4; n++) begin
      wdat[0] = 8'hF0 + 8'(n);
      wval[0] = 1'b1;
      @(negedge clk);
    end
    wval[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_pre_level", int'(lvl_v[0]), 3);
    chk("midrst_pre_busy", int'(busy_v[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_txd", int'(txd_v[0]), 1);
    chk("midrst_level", int'(lvl_v[0]), 0);
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_ovf", int'(ovf_v[0]), 0);
    chk("midrst_ready", int'(rdy[0]), 1);
    chk("midrst_idle", int'(idle_v[0]), 1);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (txd_v[0] !== 1'b1 || done_v[0] !== 1'b0) quiet++;
    end
    chk("midrst_quiet", quiet, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated write FIFO. It is the next generation of the core's serial sender and replaces its single-byte ready/done handshake. It supports configurable baud divisor, data width, parity and stop bits, and queues words so the core can burst output without polling per byte. It drives the board TX pin directly.

Parameters:
CLKS_PER_BIT, 868, CLK cycles per serial bit (>=2; 868 = 100 MHz / 115200).
DATA_BITS, 8, payload bits per frame (5..9).
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 16, FIFO entries (power of 2, >=2).

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
wr_data  in  DATA_BITS  word to transmit
wr_valid  in  1  write request; accepted on a CLK edge where wr_valid && wr_ready
wr_ready  out  1  FIFO not full
level  out  clog2(FIFO_DEPTH)+1  words queued, excluding the frame in flight
busy  out  1  frame in flight
idle  out  1  !busy && level==0
frame_done  out  1  one-cycle pulse at the end of each frame's last stop bit
overflow  out  1  sticky; set when wr_valid is asserted while wr_ready is low
txd  out  1  serial line; idles high

Behaviour:
- Reset is synchronous and active-high on RST, clocked by CLK. On reset:
  - txd=1, busy=0, frame_done=0, overflow=0, level=0, wr_ready=1, idle=1.
  - FIFO pointers clear; FSM returns to IDLE; the bit timer and bit index clear.
- Reset mid-frame aborts the frame. txd is 1 from the next edge and queued data is discarded.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of clog2(DEPTH)+1 bits; pointers wrap modulo 2*DEPTH.
  - level = wr_ptr - rd_ptr.
  - wr_ready is combinational !full and is based on the current state only. A same-cycle pop does not free a slot for a write while the FIFO is full.
  - A write attempted when full is dropped and sets overflow; FIFO contents are unchanged.
  - A simultaneous push and pop with 0 < level < DEPTH leaves level unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: txd=1. If level>0, pop the head into shift register sh, latch parity, and go to START. txd=0 is registered on that same edge.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=sh[idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PAR if PARITY!=0, else STOP.
  - PAR: txd = XOR of data, inverted for odd. So the even mode gives the XOR and odd mode gives its complement. Held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of STOP, frame_done pulses for 1 cycle.
  - At the end of STOP, if level>0 the next word is popped on that same edge and START begins immediately. There are no idle cycles between back-to-back frames. Otherwise the FSM returns to IDLE.
- Bit timer runs 0..CLKS_PER_BIT-1 and advances the state on the terminal count. Every bit is exactly CLKS_PER_BIT cycles, with no off-by-one trimming.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a write at edge n into an empty FIFO while IDLE gives level=1 after edge n. Pop occurs at edge n+1, so txd falls after edge n+1. busy=1 from edge n+1 until the edge that ends STOP with no pending word.
- wr_data is captured at the write edge; later changes to wr_data do not affect queued words.

Test Plan:
- 8N1, CLKS_PER_BIT=4; write 0x55 once -> txd: 0 (start), then data bits 1,0,1,0,1,0,1,0, then 1 (stop), each held exactly 4 cycles. frame_done pulses once 40 cycles after txd falls. idle=1 afterwards.
- PARITY=2 (even), write 0x07 -> parity bit = 1. Repeat with PARITY=1 (odd) -> parity bit = 0. Frame length = 44 cycles in both cases.
- Write 0xA1, 0xB2, 0xC3 on consecutive cycles -> level peaks at 2. Three frames are contiguous with no idle gap, for 120 cycles total of txd activity. frame_done pulses 3 times, 40 cycles apart.
- Hold the transmitter busy and write 17 words -> wr_ready=0 after the 16th queued word. The 17th write is dropped and overflow=1. The next 16 frames carry exactly the queued words, in order.
- STOP_BITS=2 -> the stop high time is 8 cycles and frame length = 44 cycles. A next word written during STOP starts exactly at the stop-bit end.
- Assert RST during the DATA bits of a frame with 3 words queued -> after the reset edge: txd=1, level=0, busy=0, overflow=0. No further frames are sent.
